// File: rtl/history_store_pkg.sv
// Shared constants, address/coordinate types and FSM encoding for the colour-history store.
package history_store_pkg;

   localparam int unsigned H_ACTIVE     = 640;
   localparam int unsigned V_ACTIVE     = 480;
   localparam int unsigned HIST_W       = 4;
   localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   localparam int unsigned ADDR_W       = 19;
   localparam int unsigned COORD_W      = 10;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      StClear     = 2'd0,
      StWaitFrame = 2'd1,
      StScan      = 2'd2
   } state_e;

endpackage

// File: rtl/history_store_if.sv
// Video-side bus of the colour-history store: frame/pixel timing, detector write port and
// the registered read results.
interface history_store_if #(
   parameter int unsigned HIST_W = history_store_pkg::HIST_W
) ();
   import history_store_pkg::*;

   logic              VGA_VS;
   logic              pixel_valid;
   logic              we;
   addr_t             write_addr;
   logic [HIST_W-1:0] updated_color_history;
   logic [HIST_W-1:0] color_history;
   logic              color_valid;
   addr_t             read_addr;
   coord_t            read_x;
   coord_t            read_y;
   logic              busy;
   logic              frame_done;

   modport master (
      output VGA_VS,
      output pixel_valid,
      output we,
      output write_addr,
      output updated_color_history,
      input  color_history,
      input  color_valid,
      input  read_addr,
      input  read_x,
      input  read_y,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  VGA_VS,
      input  pixel_valid,
      input  we,
      input  write_addr,
      input  updated_color_history,
      output color_history,
      output color_valid,
      output read_addr,
      output read_x,
      output read_y,
      output busy,
      output frame_done
   );

endinterface

// File: rtl/history_ram.sv
// Simple dual-port history memory: one write port, one read port with a registered output.
// Same-address read/write returns the old contents; the caller handles forwarding.
module history_ram #(
   parameter int unsigned Depth = history_store_pkg::FRAME_PIXELS,
   parameter int unsigned Width = history_store_pkg::HIST_W,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/history_store.sv
// Colour-history frame store: wipes memory after reset, then replays one stored history per
// active pixel in raster order while the detector writes updated histories back.
module history_store #(
   parameter int unsigned H_ACTIVE = history_store_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE = history_store_pkg::V_ACTIVE,
   parameter int unsigned HIST_W   = history_store_pkg::HIST_W
) (
   input logic            clk,
   input logic            reset,
   history_store_if.slave bus
);
   import history_store_pkg::*;

   localparam int unsigned FramePixels = H_ACTIVE * V_ACTIVE;
   localparam int unsigned RamAw       = $clog2(FramePixels);
   localparam addr_t       LastAddr    = addr_t'(FramePixels - 1);
   localparam addr_t       FrameEnd    = addr_t'(FramePixels);
   localparam coord_t      LastX       = coord_t'(H_ACTIVE - 1);
   localparam coord_t      LastY       = coord_t'(V_ACTIVE - 1);

   state_e            state_q, state_d;
   addr_t             clr_addr_q, clr_addr_d;
   logic              vs_q, vs_d;
   coord_t            x_q, x_d;
   coord_t            y_q, y_d;
   addr_t             addr_q, addr_d;
   logic              color_valid_q, color_valid_d;
   addr_t             read_addr_q, read_addr_d;
   coord_t            read_x_q, read_x_d;
   coord_t            read_y_q, read_y_d;
   logic              frame_done_q, frame_done_d;
   logic              fwd_q, fwd_d;
   logic [HIST_W-1:0] fwd_data_q, fwd_data_d;

   logic              clearing;
   logic              vs_fall;
   logic              rd_issue;
   logic              ext_wr;
   logic              last_pixel;
   logic              ram_we;
   logic [RamAw-1:0]  ram_waddr;
   logic [HIST_W-1:0] ram_wdata;
   logic [HIST_W-1:0] ram_rdata;

   always_comb begin
      clearing   = (state_q == StClear);
      vs_fall    = vs_q & ~bus.VGA_VS;
      last_pixel = (x_q == LastX) && (y_q == LastY);
      // Out-of-range detector writes are dropped rather than wrapped onto real pixels.
      ext_wr     = bus.we && !clearing && (bus.write_addr < FrameEnd);
      rd_issue   = (state_q == StScan) && bus.pixel_valid && !vs_fall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StClear;
         clr_addr_q    <= '0;
         vs_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         addr_q        <= '0;
         color_valid_q <= 1'b0;
         read_addr_q   <= '0;
         read_x_q      <= '0;
         read_y_q      <= '0;
         frame_done_q  <= 1'b0;
         fwd_q         <= 1'b0;
         fwd_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         clr_addr_q    <= clr_addr_d;
         vs_q          <= vs_d;
         x_q           <= x_d;
         y_q           <= y_d;
         addr_q        <= addr_d;
         color_valid_q <= color_valid_d;
         read_addr_q   <= read_addr_d;
         read_x_q      <= read_x_d;
         read_y_q      <= read_y_d;
         frame_done_q  <= frame_done_d;
         fwd_q         <= fwd_d;
         fwd_data_q    <= fwd_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StClear:     if (clr_addr_q == LastAddr) state_d = StWaitFrame;
         StWaitFrame: if (vs_fall) state_d = StScan;
         StScan:      if (rd_issue && last_pixel) state_d = StWaitFrame;
         default:     state_d = StClear;
      endcase
   end

   always_comb begin
      vs_d       = bus.VGA_VS;
      clr_addr_d = clearing ? clr_addr_q + addr_t'(1) : clr_addr_q;

      // The linear address runs alongside x so no y*H_ACTIVE product is ever needed.
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
      if (vs_fall && !clearing) begin
         x_d    = '0;
         y_d    = '0;
         addr_d = '0;
      end else if (rd_issue) begin
         if (last_pixel) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
         end else if (x_q == LastX) begin
            x_d    = '0;
            y_d    = y_q + coord_t'(1);
            addr_d = addr_q + addr_t'(1);
         end else begin
            x_d    = x_q + coord_t'(1);
            addr_d = addr_q + addr_t'(1);
         end
      end

      color_valid_d = rd_issue;
      frame_done_d  = rd_issue && last_pixel;
      read_addr_d   = rd_issue ? addr_q : read_addr_q;
      read_x_d      = rd_issue ? x_q : read_x_q;
      read_y_d      = rd_issue ? y_q : read_y_q;
      fwd_d         = rd_issue && ext_wr && (bus.write_addr == addr_q);
      fwd_data_d    = bus.updated_color_history;
   end

   always_comb begin
      ram_we    = clearing || ext_wr;
      ram_waddr = clearing ? clr_addr_q[RamAw-1:0] : bus.write_addr[RamAw-1:0];
      ram_wdata = clearing ? '0 : bus.updated_color_history;

      bus.color_history = '0;
      if (color_valid_q) begin
         bus.color_history = fwd_q ? fwd_data_q : ram_rdata;
      end
      bus.color_valid = color_valid_q;
      bus.read_addr   = read_addr_q;
      bus.read_x      = read_x_q;
      bus.read_y      = read_y_q;
      bus.busy        = clearing;
      bus.frame_done  = frame_done_q;
   end

   history_ram #(
      .Depth (FramePixels),
      .Width (HIST_W),
      .AddrW (RamAw)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (addr_q[RamAw-1:0]),
      .rdata_o (ram_rdata)
   );

endmodule

// File: doc/history_store.md
HISTORY_STORE -- requirements
Module: history_store

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, 480, active lines per frame.
REQ-003 Parameter HIST_W, 4, color-history bits per pixel.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 VGA_VS  input  1  vertical sync; falling edge marks frame start.
REQ-007 pixel_valid  input  1  one active-video pixel presented this cycle.
REQ-008 we  input  1  history write strobe from the detector.
REQ-009 write_addr  input  19  pixel address to write.
REQ-010 updated_color_history  input  HIST_W  write data.
REQ-011 color_history  output  HIST_W  stored history for read_addr.
REQ-012 color_valid  output  1  color_history/read_addr/read_x/read_y valid this cycle.
REQ-013 read_addr  output  19  linear address, read_y*H_ACTIVE+read_x.
REQ-014 read_x  output  10  pixel column, 0..H_ACTIVE-1.
REQ-015 read_y  output  10  pixel row, 0..V_ACTIVE-1.
REQ-016 busy  output  1  high while memory clear is in progress.
REQ-017 frame_done  output  1  one-cycle pulse after last pixel of a frame is read.

Function
REQ-018 FSM states CLEAR, WAIT_FRAME, SCAN; reset enters CLEAR.
REQ-019 CLEAR: write 0 to one address per cycle, 0..H_ACTIVE*V_ACTIVE-1 ascending; busy=1; external we ignored; color_valid=0.
REQ-020 CLEAR -> WAIT_FRAME the cycle after address 307199 is written (307200 cycles of busy=1 after reset deasserts).
REQ-021 WAIT_FRAME -> SCAN on VS falling edge (VGA_VS registered; prev=1, current=0); x,y counters cleared to 0.
REQ-022 SCAN: each pixel_valid cycle issues a read at (x,y) then advances x; x wraps at H_ACTIVE-1 to 0 with y+1.
REQ-023 Read latency exactly 1 cycle: color_valid=1 the cycle after a pixel_valid read, with read_addr/read_x/read_y registered to match that read.
REQ-024 pixel_valid=0 in SCAN: counters hold, color_valid=0 next cycle.
REQ-025 Read at (H_ACTIVE-1,V_ACTIVE-1): FSM -> WAIT_FRAME; frame_done=1 in the same cycle color_valid=1 for that pixel.
REQ-026 VS falling edge during SCAN: counters resync to (0,0), state stays SCAN, frame_done not asserted.
REQ-027 Write port active in WAIT_FRAME and SCAN: we=1 writes updated_color_history to write_addr at that clock edge.
REQ-028 write_addr >= 307200: write dropped, no aliasing.
REQ-029 Same-cycle read and write to equal address: read returns the new write data (write-first forwarding).
REQ-030 Read address address address equal to write issued previous cycle returns that written data (no stale read).
REQ-031 Address arithmetic: read_addr computed as running counter incremented with x, cleared at frame start; no multiplier.

Reset
REQ-032 Reset mid-clear or mid-scan restarts CLEAR from address 0.
REQ-033 Reset values: color_history=0, color_valid=0, read_addr=0, read_x=0, read_y=0, busy=1 (cycle after reset asserted), frame_done=0.
REQ-034 Stored history contents undefined until CLEAR completes; only busy=0 guarantees all-zero memory.

Structure
REQ-035 Shared package holds H_ACTIVE, V_ACTIVE, HIST_W, FRAME_PIXELS=307200 and FSM state encodings.
REQ-036 One sub-module history_ram: simple dual-port, 1 write port, 1 read port, 1-cycle registered read, HIST_W x FRAME_PIXELS, inferable as block RAM; forwarding lives in history_store.

Verification
REQ-037 Reset 1 cycle then release -> busy=1 for exactly 307200 cycles, then busy=0; read of any address returns 4'b0000.
REQ-038 VS fall, pixel_valid continuous 307200 cycles -> color_valid each following cycle, read_x 639->0 with read_y+1, read_addr 0..307199, frame_done single pulse with (639,479).
REQ-039 Write 4'b1011 to addr 1285 in WAIT_FRAME, scan frame -> color_valid cycle with read_x=5, read_y=2 shows color_history=4'b1011.
REQ-040 Same cycle read and we to addr 100 data 4'b0110 -> next cycle color_history=4'b0110; write to 307200 -> no memory change.
REQ-041 pixel_valid gapped 1-of-3 -> counters advance only on valid cycles, color_valid mirrors pattern delayed 1 cycle.
REQ-042 Reset asserted at pixel (320,240) -> outputs to reset values, busy=1, full CLEAR repeats, next frame starts at (0,0).
